sirv_gnrl_rr_arb: RTL and testbench

SIRV_GNRL_RR_ARB -- requirements
Module: sirv_gnrl_rr_arb

---
 rtl/sirv_gnrl_arb_pkg.sv | 20 ++
 rtl/sirv_gnrl_dfflr.sv | 21 ++
 rtl/sirv_gnrl_rr_pick.sv | 33 +++
 rtl/sirv_gnrl_rr_arb.sv | 117 +++++++++++
 tb/tb_sirv_gnrl_rr_arb.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sirv_gnrl_arb_pkg.sv
// Shared constants for the round-robin memory-port arbiter.
// State encoding and default geometry.
package sirv_gnrl_arb_pkg;

    localparam int ARB_N_DEF  = 4;
    localparam int ARB_AW_DEF = 32;
    localparam int ARB_DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Index width; kept at least 1 bit so N=1 corners still elaborate.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enabled flop with asynchronous active-low reset to zero.
// Used for every architectural register in the arbiter.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          reset
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_gnrl_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Wraps modulo N.
module sirv_gnrl_rr_pick
    import sirv_gnrl_arb_pkg::*;
#(
    parameter int N  = ARB_N_DEF,
    parameter int PW = ptr_w(ARB_N_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    int idx;

    // Scan farthest offset first so the nearest match wins last.
    always_comb begin
        winner = '0;
        any    = |req;
        idx    = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/sirv_gnrl_rr_arb.sv
// N-way round-robin arbiter onto one memory port.
// At most one transaction in flight: IDLE -> CMD -> RESP.
module sirv_gnrl_rr_arb
    import sirv_gnrl_arb_pkg::*;
#(
    parameter int N  = ARB_N_DEF,
    parameter int AW = ARB_AW_DEF,
    parameter int DW = ARB_DW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N-1:0]    req_wen,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_wen,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_resp_valid,
    input  logic [DW-1:0]   m_resp_rdata
);

    localparam int PW = ptr_w(N);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [PW-1:0] gnt_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] winner;
    logic          any;
    logic          grant_en;
    int            gi;

    assign state = arb_state_e'(state_q);

    sirv_gnrl_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign grant_en = (state == IDLE) & any;
    assign ptr_d    = (winner == PW'(N - 1)) ? '0
                    : winner + 1'b1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any)          state_nxt = CMD;
            CMD:  if (m_ready)      state_nxt = RESP;
            RESP: if (m_resp_valid) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign state_d = state_nxt;

    sirv_gnrl_dfflr #(.DW(2)) u_state (
        .lden  (1'b1),
        .dnxt  (state_d),
        .qout  (state_q),
        .clk   (clk),
        .reset (reset)
    );

    sirv_gnrl_dfflr #(.DW(PW)) u_gnt (
        .lden  (grant_en),
        .dnxt  (winner),
        .qout  (gnt_q),
        .clk   (clk),
        .reset (reset)
    );

    sirv_gnrl_dfflr #(.DW(PW)) u_ptr (
        .lden  (grant_en),
        .dnxt  (ptr_d),
        .qout  (ptr_q),
        .clk   (clk),
        .reset (reset)
    );

    // Command fields come from the latched grant, never a fresh pick.
    always_comb begin
        gi         = int'(gnt_q);
        req_ready  = '0;
        resp_valid = '0;
        m_valid    = 1'b0;
        m_wen      = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        if (state == CMD) begin
            m_valid       = 1'b1;
            m_wen         = req_wen[gi];
            m_addr        = req_addr[gi*AW +: AW];
            m_wdata       = req_wdata[gi*DW +: DW];
            req_ready[gi] = m_ready;
        end
        if (state == RESP) begin
            resp_valid[gi] = m_resp_valid;
        end
    end

    assign resp_rdata = m_resp_rdata;

endmodule

// File: tb/tb_sirv_gnrl_rr_arb.sv
// Directed bench for sirv_gnrl_rr_arb with hand-computed expectations.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_sirv_gnrl_rr_arb;
    import sirv_gnrl_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wen;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            m_valid;
    logic            m_ready;
    logic            m_wen;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_resp_valid;
    logic [DW-1:0]   m_resp_rdata;

    int passes = 0;
    int total  = 0;

    sirv_gnrl_rr_arb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_wen        (m_wen),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_resp_valid (m_resp_valid),
        .m_resp_rdata (m_resp_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i * 16);
    endfunction

    function automatic logic [31:0] wdat_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h",
                    tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cmd(input string tag, input int g,
                           input logic [N-1:0] rdy);
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
        chk({tag, "_gnt"}, 32'(dut.gnt_q), 32'(g));
        chk({tag, "_addr"}, m_addr, addr_of(g));
        chk({tag, "_wdata"}, m_wdata, wdat_of(g));
        chk({tag, "_wen"}, 32'(m_wen), 32'(req_wen[g]));
        chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = '0;
        req_wen      = 4'b1010;
        m_ready      = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = addr_of(i);
            req_wdata[i*DW +: DW] = wdat_of(i);
        end

        // Reset state
        #2;
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
        step();
        step();
        reset = 1'b1;

        // Fairness: all requesting, port always ready and answering
        req_valid    = 4'b1111;
        m_ready      = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'h5555_0000;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("fair_idle", 32'(dut.state_q), 32'(IDLE));
            step();
            chk_cmd("fair", k % N, 4'(1 << (k % N)));
            step();
            chk("fair_resp", 32'(resp_valid),
                32'(1 << (k % N)));
            step();
        end
        chk("fair_ptr", 32'(dut.ptr_q), 32'd1);

        // Single request, ptr=1 -> requester 2 wins
        req_valid    = 4'b0100;
        m_resp_valid = 1'b0;
        #1;
        chk("single_t0", 32'(m_valid), 32'd0);
        step();
        chk_cmd("single", 2, 4'b0100);
        req_valid    = 4'b0000;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("spur_cmd_resp", 32'(resp_valid), 32'd0);
        chk("spur_cmd_state", 32'(dut.state_q), 32'(CMD));
        step();
        chk("single_resp", 32'(resp_valid), 32'b0100);
        chk("single_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("single_ptr", 32'(dut.ptr_q), 32'd3);
        step();

        // Spurious response in IDLE
        m_resp_rdata = 32'h1234_5678;
        #1;
        chk("spur_idle_resp", 32'(resp_valid), 32'd0);
        chk("spur_idle_rdata", resp_rdata, 32'h1234_5678);
        step();
        chk("spur_idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("spur_idle_ptr", 32'(dut.ptr_q), 32'd3);

        // Pointer wrap: ptr=3 with 1001 -> 3 then 0
        req_valid = 4'b1001;
        step();
        chk_cmd("wrap3", 3, 4'b1000);
        chk("wrap3_ptr", 32'(dut.ptr_q), 32'd0);
        step();
        step();
        step();
        chk_cmd("wrap0", 0, 4'b0001);
        chk("wrap0_ptr", 32'(dut.ptr_q), 32'd1);
        req_valid = 4'b0000;
        step();
        step();

        // Backpressure on a write, grant held through req drop
        req_valid    = 4'b0010;
        m_ready      = 1'b0;
        m_resp_valid = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk_cmd("bp", 1, 4'b0000);
            chk("bp_ptr", 32'(dut.ptr_q), 32'd2);
            if (c == 2) req_valid = 4'b0101;
            step();
        end
        m_ready = 1'b1;
        #1;
        chk_cmd("bp_acc", 1, 4'b0010);
        req_valid = 4'b0000;
        step();
        chk("wr_wait_resp", 32'(resp_valid), 32'd0);
        step();
        chk("wr_wait_state", 32'(dut.state_q), 32'(RESP));
        m_resp_valid = 1'b1;
        #1;
        chk("wr_ack", 32'(resp_valid), 32'b0010);
        step();
        chk("wr_idle", 32'(dut.state_q), 32'(IDLE));

        // Reset while in RESP
        req_valid    = 4'b0001;
        m_resp_valid = 1'b0;
        step();
        req_valid = 4'b0000;
        step();
        m_resp_valid = 1'b1;
        #1;
        chk("prerst_resp", 32'(resp_valid), 32'b0001);
        reset = 1'b0;
        #1;
        chk("arst_resp", 32'(resp_valid), 32'd0);
        chk("arst_state", 32'(dut.state_q), 32'(IDLE));
        chk("arst_ptr", 32'(dut.ptr_q), 32'd0);
        chk("arst_gnt", 32'(dut.gnt_q), 32'd0);
        m_resp_valid = 1'b0;
        step();
        reset     = 1'b1;
        req_valid = 4'b0110;
        step();
        chk_cmd("post_rst", 1, 4'b0010);
        chk("post_rst_ptr", 32'(dut.ptr_q), 32'd2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
